lcm_refresh_scheduler: RTL



---
 rtl/lcm_pkg.sv | 14 +
 rtl/lcm_period_timer.sv | 48 ++++
 rtl/lcm_refresh_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/lcm_pkg.sv
// Shared constants for the LCM refresh scheduler: FSM state encoding and the
// smallest refresh period the timer will honour.
package lcm_pkg;

  localparam int unsigned LCM_MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    LCM_SCHED_IDLE = 2'd0,
    LCM_SCHED_WAIT = 2'd1,
    LCM_SCHED_SWAP = 2'd2,
    LCM_SCHED_BUSY = 2'd3
  } lcm_sched_state_e;

endpackage : lcm_pkg

// File: rtl/lcm_period_timer.sv
// Free-running refresh-period counter with a clamped period and a one-cycle
// expire strobe; held at zero while run is low.
module lcm_period_timer
  import lcm_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MIN_PERIOD = LCM_MIN_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] period,
  output logic             expire
);

  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] eff_period;
  logic [WIDTH-1:0] last_count;

  assign eff_period = (period < MIN_P) ? MIN_P : period;
  assign last_count = eff_period - WIDTH'(1);

  // >= rather than == so a period shrunk below the current count still fires.
  assign expire = run && (count_q >= last_count);

  always_comb begin
    count_d = count_q;
    if (!run) begin
      count_d = '0;
    end else if (expire) begin
      count_d = '0;
    end else begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : lcm_period_timer

// File: rtl/lcm_refresh_scheduler.sv
// Refresh sequencer for the double-buffered LCM frame RAM: bank swap, periodic
// request_update to the scan engine, frame counting and overrun reporting.
module lcm_refresh_scheduler
  import lcm_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned FRAME_COUNT_WIDTH  = 16,
  parameter int unsigned MIN_PERIOD         = LCM_MIN_PERIOD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_enable,
  input  logic                          cfg_commit_only,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_period,
  input  logic                          frame_commit,
  input  logic                          display_busy,
  input  logic                          overrun_clr,
  output logic                          request_update,
  output logic                          front_bank,
  output logic                          back_bank,
  output logic                          commit_pending,
  output logic [FRAME_COUNT_WIDTH-1:0]  frame_count,
  output logic                          overrun,
  output logic [1:0]                    sched_state
);

  // Handshake: request_update is a single-cycle start pulse, visible in the
  // first BUSY cycle; display_busy is ignored in that cycle and the frame ends
  // on the first later cycle in which display_busy is low.

  lcm_sched_state_e state_q, state_d;
  logic due_q, due_d;
  logic req_q, req_d;
  logic front_q, front_d;
  logic pend_q, pend_d;
  logic ovr_q, ovr_d;
  logic first_q, first_d;
  logic [FRAME_COUNT_WIDTH-1:0] fc_q, fc_d;

  logic run;
  logic expire;
  logic swap_ok;
  logic due_now;
  logic ovr_set;

  assign run = (state_q != LCM_SCHED_IDLE);

  lcm_period_timer #(
    .WIDTH      (C_S_AXI_DATA_WIDTH),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .period (cfg_period),
    .expire (expire)
  );

  // In commit-only mode a due refresh is dropped unless a new frame is waiting.
  assign swap_ok = cfg_enable && !(cfg_commit_only && !pend_q);
  assign due_now = due_q || expire;
  assign ovr_set = expire && ((state_q == LCM_SCHED_SWAP) || (state_q == LCM_SCHED_BUSY));

  always_comb begin
    state_d = state_q;
    due_d   = due_q;
    req_d   = 1'b0;
    front_d = front_q;
    pend_d  = pend_q;
    fc_d    = fc_q;
    first_d = 1'b0;

    case (state_q)
      LCM_SCHED_IDLE: begin
        due_d = 1'b0;
        if (cfg_enable) begin
          state_d = LCM_SCHED_WAIT;
        end
      end

      LCM_SCHED_WAIT: begin
        if (!cfg_enable) begin
          state_d = LCM_SCHED_IDLE;
          due_d   = 1'b0;
        end else if (due_now) begin
          if (swap_ok) begin
            state_d = LCM_SCHED_SWAP;
            due_d   = 1'b1;
          end else begin
            due_d = 1'b0;
          end
        end
      end

      LCM_SCHED_SWAP: begin
        if (pend_q) begin
          front_d = ~front_q;
          pend_d  = 1'b0;
        end
        req_d   = 1'b1;
        due_d   = expire;
        first_d = 1'b1;
        state_d = LCM_SCHED_BUSY;
      end

      LCM_SCHED_BUSY: begin
        if (expire) begin
          due_d = 1'b1;
        end
        if (!first_q && !display_busy) begin
          fc_d = fc_q + FRAME_COUNT_WIDTH'(1);
          if (due_now && swap_ok) begin
            state_d = LCM_SCHED_SWAP;
          end else begin
            due_d   = 1'b0;
            state_d = cfg_enable ? LCM_SCHED_WAIT : LCM_SCHED_IDLE;
          end
        end
      end

      default: begin
        state_d = LCM_SCHED_IDLE;
        due_d   = 1'b0;
      end
    endcase

    // A commit landing on the swap cycle belongs to the next frame.
    if (frame_commit) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LCM_SCHED_IDLE;
      due_q   <= 1'b0;
      req_q   <= 1'b0;
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      first_q <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      due_q   <= due_d;
      req_q   <= req_d;
      front_q <= front_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      first_q <= first_d;
      fc_q    <= fc_d;
    end
  end

  assign request_update = req_q;
  assign front_bank     = front_q;
  assign back_bank      = ~front_q;
  assign commit_pending = pend_q;
  assign frame_count    = fc_q;
  assign overrun        = ovr_q;
  assign sched_state    = state_q;

endmodule : lcm_refresh_scheduler
